// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states and framing constants for the a0 word UART transmitter
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int BITS_PER_BYTE = 8;
  // bit i of byte b, bytes numbered from the most significant end
  function automatic logic word_bit(input logic [31:0] w, input logic [1:0] b, input logic [2:0] i);
    return w[{~b, i}];
  endfunction
endpackage

// File: rtl/word_fifo.sv
// word_fifo: power-of-two word FIFO; push is ignored when full, pop when empty
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/a0_uart_tx.sv
// a0_uart_tx: queues each change of the cpu a0 value and sends it as four 8N1 UART bytes,
// most significant byte first
module a0_uart_tx
  import uart_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [WIDTH-1:0]              a0_in,
  input  logic                          capture_en,
  output logic                          tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(BITS_PER_BYTE - 1);
  localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WORD - 1);
  state_t state, state_d;
  logic [BW-1:0] baud, baud_d;
  logic [2:0] bit_idx, bit_d;
  logic [1:0] byte_idx, byte_d;
  logic [WIDTH-1:0] word, word_d, prev_a0, fifo_dout;
  logic tx_d, change, full, empty, pop, bit_end;
  assign change = capture_en && (a0_in != prev_a0);
  assign bit_end = baud == BAUD_LAST;
  assign busy = (state != IDLE) || !empty;
  word_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(change),
    .pop(pop),
    .din(a0_in),
    .dout(fifo_dout),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  // prev_a0 follows a0_in whenever capture is enabled, even if the push is dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev_a0 <= '0;
      overflow <= 1'b0;
    end else begin
      if (capture_en) prev_a0 <= a0_in;
      if (change && full) overflow <= 1'b1;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      word <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_d;
      baud <= baud_d;
      bit_idx <= bit_d;
      byte_idx <= byte_d;
      word <= word_d;
      tx <= tx_d;
    end
  always_comb begin
    state_d = state;
    baud_d = baud + 1'b1;
    bit_d = bit_idx;
    byte_d = byte_idx;
    word_d = word;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop = 1'b1;
          word_d = fifo_dout;
          byte_d = '0;
          bit_d = '0;
          state_d = START;
        end
      end
      START:
        if (bit_end) begin
          baud_d = '0;
          bit_d = '0;
          state_d = DATA;
        end
      DATA:
        if (bit_end) begin
          baud_d = '0;
          if (bit_idx == BIT_LAST) state_d = STOP;
          else bit_d = bit_idx + 1'b1;
        end
      STOP:
        if (bit_end) begin
          baud_d = '0;
          if (byte_idx == BYTE_LAST) state_d = IDLE;
          else begin
            byte_d = byte_idx + 1'b1;
            bit_d = '0;
            state_d = START;
          end
        end
      default: state_d = IDLE;
    endcase
  end
  // tx is registered from the next-state view so the line changes on the same edge as the state
  always_comb
    tx_d = (state_d == START) ? 1'b0 :
           (state_d == DATA)  ? word_bit(word_d, byte_d, bit_d) : 1'b1;
endmodule

// File: tb/tb_a0_uart_tx.sv
// tb_a0_uart_tx: directed stimulus with a frame-level reference model checked every cycle
module tb_a0_uart_tx;
  localparam int C = 4;
  localparam int D = 4;
  localparam int FRAME = 40 * C;
  localparam bit A5_BITS [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] a0_in = '0;
  logic capture_en = 1'b0;
  logic tx, busy, overflow;
  logic [2:0] fifo_count;
  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  logic [31:0] q [$];
  logic m_frame [FRAME];
  int m_pos = -1;
  logic [31:0] m_prev = '0;
  logic m_ovf = 1'b0;
  logic m_chg, m_full, m_pop;
  logic [31:0] m_word;
  logic [31:0] vals [6] = '{32'h11111111, 32'h22222222, 32'h33333333,
                            32'h44444444, 32'h55555555, 32'h66666666};

  a0_uart_tx #(.WIDTH(32), .CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .clk(clk),
    .rst(rst),
    .a0_in(a0_in),
    .capture_en(capture_en),
    .tx(tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // expected line waveform for one word: per byte a start bit, 8 data bits LSB first, a stop bit
  task automatic load_frame(input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      logic [7:0] byt;
      byt = 8'(w >> (24 - 8 * b));
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < C; c++) begin
          if (k == 0) m_frame[(10 * b + k) * C + c] = 1'b0;
          else if (k == 9) m_frame[(10 * b + k) * C + c] = 1'b1;
          else m_frame[(10 * b + k) * C + c] = byt[k - 1];
        end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      m_pos = -1;
      m_prev = '0;
      m_ovf = 1'b0;
    end else begin
      m_chg = capture_en && (a0_in != m_prev);
      m_full = q.size() == D;
      m_pop = (m_pos < 0) && (q.size() > 0);
      if (m_pos >= 0) m_pos = (m_pos == FRAME - 1) ? -1 : m_pos + 1;
      if (m_pop) begin
        m_word = q.pop_front();
        load_frame(m_word);
        m_pos = 0;
      end
      if (m_chg) begin
        if (m_full) m_ovf = 1'b1;
        else q.push_back(a0_in);
      end
      if (capture_en) m_prev = a0_in;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_tx", 32'(tx), 32'(m_pos < 0 ? 1'b1 : m_frame[m_pos]));
      chk("cyc_busy", 32'(busy), 32'((m_pos >= 0) || (q.size() > 0)));
      chk("cyc_count", 32'(fifo_count), 32'(q.size()));
      chk("cyc_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  initial begin
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    repeat (3) tick();
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_count", 32'(fifo_count), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    // first edge after release is a change because prev_a0 restarts at zero
    a0_in = 32'h000000A5;
    capture_en = 1'b1;
    rst = 1'b1;
    tick();
    chk("a5_push_count", 32'(fifo_count), 32'd1);
    chk("a5_push_tx", 32'(tx), 32'd1);
    chk("a5_push_busy", 32'(busy), 32'd1);
    tick();
    chk("a5_start_tx", 32'(tx), 32'd0);
    chk("a5_start_count", 32'(fifo_count), 32'd0);
    for (int p = 1; p <= FRAME; p++) begin
      tick();
      if (p == 5) chk("a5_byte0_bit0", 32'(tx), 32'd0);
      for (int j = 0; j < 8; j++)
        if (p == 124 + 4 * j + 1) chk($sformatf("a5_byte3_bit%0d", j), 32'(tx), 32'(A5_BITS[j]));
      if (p == FRAME - 1) chk("a5_last_busy", 32'(busy), 32'd1);
      if (p == FRAME) chk("a5_done_busy", 32'(busy), 32'd0);
    end
    repeat (500) tick();
    chk("hold_count", 32'(fifo_count), 32'd0);
    chk("hold_busy", 32'(busy), 32'd0);
    capture_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a0_in = 32'h1000 + i;
      tick();
    end
    a0_in = 32'h000000A5;
    capture_en = 1'b1;
    repeat (5) tick();
    chk("nocap_count", 32'(fifo_count), 32'd0);
    chk("nocap_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      a0_in = vals[i];
      tick();
      chk($sformatf("burst_count%0d", i), 32'(fifo_count), (i < 2) ? 32'd1 : (i < 5) ? 32'(i) : 32'd4);
    end
    chk("burst_overflow", 32'(overflow), 32'd1);
    repeat (5 * (FRAME + 1) + 20) tick();
    chk("burst_drain_busy", 32'(busy), 32'd0);
    chk("burst_sticky_overflow", 32'(overflow), 32'd1);
    a0_in = 32'hAAAA0001;
    tick();
    a0_in = 32'hAAAA0002;
    tick();
    a0_in = 32'hAAAA0003;
    tick();
    repeat (FRAME - 1) tick();
    chk("pushpop_pre_count", 32'(fifo_count), 32'd2);
    chk("pushpop_pre_tx", 32'(tx), 32'd1);
    a0_in = 32'hAAAA0004;
    tick();
    chk("pushpop_count", 32'(fifo_count), 32'd2);
    chk("pushpop_tx", 32'(tx), 32'd0);
    repeat (3 * (FRAME + 1) + 20) tick();
    chk("pushpop_drain_busy", 32'(busy), 32'd0);
    a0_in = 32'h12345678;
    tick();
    a0_in = 32'h9ABCDEF0;
    tick();
    repeat (93) tick();
    chk("abort_pre_tx", 32'(tx), 32'd1);
    chk("abort_pre_count", 32'(fifo_count), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_count", 32'(fifo_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    capture_en = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (200) tick();
    chk("abort_after_busy", 32'(busy), 32'd0);
    chk("abort_after_tx", 32'(tx), 32'd1);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/a0_uart_tx.md
A0_UART_TX -- requirements
Module: a0_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the a0 word width; only 32 is supported.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per UART bit; legal range is 2 or more.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, giving the word FIFO depth; must be a power of two, 2 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port a0_in, input, WIDTH bits: the cpu a0_output value.
REQ-007 SHALL have port capture_en, input, 1 bit: when 1, changes on a0_in are queued.
REQ-008 SHALL have port tx, output, 1 bit: UART serial line, idle high.
REQ-009 SHALL have port busy, output, 1 bit: 1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag set when a word is dropped.
REQ-011 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the FIFO occupancy.

Function
REQ-012 SHALL hold a register prev_a0; a "change" is capture_en=1 and a0_in != prev_a0.
REQ-013 SHALL load prev_a0 from a0_in on every clock edge where capture_en=1, whether or not the push is accepted.
REQ-014 SHALL push a0_in into the FIFO on the edge ending a change cycle, if the FIFO is not full.
REQ-015 SHALL, on a change while the FIFO is full, drop the word and set overflow=1; fullness is evaluated before any same-cycle pop.
REQ-016 SHALL allow a push and a pop in the same cycle when the FIFO is not full; fifo_count is then unchanged.
REQ-017 SHALL implement FIFO pointers that wrap modulo FIFO_DEPTH, with count held in the range 0..FIFO_DEPTH.
REQ-018 SHALL implement an FSM with states IDLE, START, DATA and STOP.
REQ-019 SHALL, in IDLE with the FIFO non-empty, pop a word into the shift register, set byte_idx=0 and go to START on the same edge.
REQ-020 SHALL, in IDLE with the FIFO empty, stay in IDLE.
REQ-021 SHALL register tx: 1 in IDLE and STOP, 0 in START, and the current data bit in DATA.
REQ-022 SHALL hold each of the START, DATA and STOP states for exactly CLKS_PER_BIT clocks per bit, timed by a baud counter that restarts on every state or bit change.
REQ-023 SHALL send 8 data bits per byte, LSB first, using bit_idx 0..7, then go to STOP.
REQ-024 SHALL send 4 bytes per word, most significant byte (bits 31:24) first, least significant byte last.
REQ-025 SHALL, at the end of STOP, go to START for the next byte if byte_idx<3, otherwise go to IDLE.
REQ-026 SHALL, for a change ending at edge k with an empty FIFO and the FSM in IDLE, push at edge k, pop at edge k+1 and drive tx low from edge k+1.
REQ-027 SHALL take exactly 40*CLKS_PER_BIT clocks per word, from START entry to IDLE re-entry.
REQ-028 SHALL give a capture_en drop mid-word no effect on the word in flight.

Reset
REQ-029 SHALL, while rst=0, immediately force: tx=1, busy=0, overflow=0, fifo_count=0, FSM=IDLE, prev_a0=0, all counters and pointers 0.
REQ-030 SHALL, when reset asserts mid-word, abort the word and discard FIFO contents; tx returns high with no stop bit.
REQ-031 SHALL, after rst deasserts, treat a nonzero a0_in with capture_en=1 as a change on the first clock edge.

Structure
REQ-032 SHALL place the state enum (IDLE, START, DATA, STOP), BYTES_PER_WORD=4 and BITS_PER_BYTE=8 in shared package uart_pkg.
REQ-033 SHALL implement the FIFO as sub-module word_fifo (push, pop, din, dout, full, empty, count); the FSM, baud counter and change detector stay in a0_uart_tx.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-034 SHALL cover: reset release, capture_en=1, a0_in=32'h000000A5 -> tx low at next edge; bytes 00,00,00,A5 (A5 LSB first 1,0,1,0,0,1,0,1); frame 160 clocks; then busy=0.
REQ-035 SHALL cover: a0_in held constant for 500 clocks after its first send -> no further frame, fifo_count=0.
REQ-036 SHALL cover: 6 distinct a0_in values on consecutive cycles -> first 5 accepted (1 popped at once, 4 queued), 6th dropped, overflow=1, 5 words sent in order.
REQ-037 SHALL cover: change arriving in the same cycle as an IDLE pop with count=2 -> fifo_count stays 2.
REQ-038 SHALL cover: rst pulsed low during the DATA state of byte 2 -> tx=1 and fifo_count=0 immediately, no residual bits after release.
REQ-039 SHALL cover: capture_en=0 while a0_in toggles -> nothing queued; capture_en then set with a0_in unchanged since last capture -> nothing queued.
